// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT header: default sizes, read-FSM state codes and the bit-reversal helper.
package fft_bitrev_reorder_pkg;

  localparam int unsigned MAX_LOG_N     = 12;
  localparam int unsigned DEFAULT_LOG_N = 6;
  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_READ = 1'b1;

  // Reverse the low log_n bits of idx; bits above log_n come back as zero.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] idx,
                                                  input int unsigned log_n);
    logic [MAX_LOG_N-1:0] src;
    logic [MAX_LOG_N-1:0] dst;
    src = idx;
    dst = '0;
    for (int unsigned b = 0; b < MAX_LOG_N; b++) begin
      if (b < log_n) begin
        dst = {dst[MAX_LOG_N-2:0], src[0]};
        src = src >> 1;
      end
    end
    return dst;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port reorder storage: one write port, one read port with registered data.
module fft_reorder_ram #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong output reorder buffer: frames arrive in bit-reversed order and leave
// as contiguous natural-order bursts.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LOG_N = DEFAULT_LOG_N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
);

  localparam int unsigned AW = LOG_N + 1;
  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [LOG_N-1:0] LAST = '1;

  logic [LOG_N-1:0] wcnt;
  logic [LOG_N-1:0] waddr_idx;
  logic             wbank;
  logic [LOG_N-1:0] raddr;
  logic             rbank;
  logic [1:0]       full;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic             state;
  logic             state_next;
  logic             issue_c;
  logic             wrap_c;
  logic             issue_d;
  logic [DW-1:0]    rdata;

  assign waddr_idx = LOG_N'(bitrev(MAX_LOG_N'(wcnt), LOG_N));

  // Bank handoff: the writer marks a bank full on its last sample, the reader frees it on its last read.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (idata_en && (wcnt == LAST)) full_set[wbank] = 1'b1;
    if (wrap_c)                     full_clr[rbank] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      full  <= '0;
    end else begin
      if (idata_en) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) wbank <= ~wbank;
      end
      full <= (full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A same-cycle fill of the other bank keeps the burst going without a bubble.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (full[rbank]) state_next = ST_READ;
      ST_READ: if ((raddr == LAST) && !(full[~rbank] || full_set[~rbank])) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_c = 1'b0;
    wrap_c  = 1'b0;
    if (state == ST_READ) begin
      issue_c = 1'b1;
      wrap_c  = (raddr == LAST);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raddr    <= '0;
      rbank    <= 1'b0;
      issue_d  <= 1'b0;
      odata_en <= 1'b0;
    end else begin
      if (issue_c) raddr <= raddr + 1'b1;
      if (wrap_c)  rbank <= ~rbank;
      issue_d  <= issue_c;
      odata_en <= issue_d;
    end
  end

  always_ff @(posedge clock) begin
    if (issue_d) {odata_r, odata_i} <= rdata;
  end

  fft_reorder_ram #(.AW(AW), .DW(DW)) u_ram (
    .clock (clock),
    .wen   (idata_en),
    .waddr ({wbank, waddr_idx}),
    .wdata ({idata_r, idata_i}),
    .ren   (issue_c),
    .raddr ({rbank, raddr}),
    .rdata (rdata)
  );

  ovf_check: assert property (@(posedge clock) disable iff (reset)
    !(idata_en && (wcnt == LAST) && full[wbank] && !full_clr[wbank]));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder at three sizes (N=64/16-bit, N=4/8-bit, N=2/8-bit).
module tb_fft_bitrev_reorder;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    longint      c;
  } exp_t;

  logic clock;
  logic reset;
  logic        en    [3];
  logic [15:0] ir    [3];
  logic [15:0] ii    [3];
  logic        oen   [3];
  logic [15:0] ordat [3];
  logic [15:0] oidat [3];
  logic [15:0] or0, oi0;
  logic [7:0]  or1, oi1, or2, oi2;

  int     logn [3] = '{6, 2, 1};
  exp_t   q [3][$];
  logic [15:0] fr [3][64];
  logic [15:0] fi [3][64];
  int     cnt [3];
  longint next_free [3];
  longint cyc;
  int     n_checks;
  int     n_fail;

  fft_bitrev_reorder #(.WIDTH(16), .LOG_N(6)) dut0 (
    .clock(clock), .reset(reset), .idata_en(en[0]), .idata_r(ir[0]), .idata_i(ii[0]),
    .odata_en(oen[0]), .odata_r(or0), .odata_i(oi0));
  fft_bitrev_reorder #(.WIDTH(8), .LOG_N(2)) dut1 (
    .clock(clock), .reset(reset), .idata_en(en[1]), .idata_r(ir[1][7:0]), .idata_i(ii[1][7:0]),
    .odata_en(oen[1]), .odata_r(or1), .odata_i(oi1));
  fft_bitrev_reorder #(.WIDTH(8), .LOG_N(1)) dut2 (
    .clock(clock), .reset(reset), .idata_en(en[2]), .idata_r(ir[2][7:0]), .idata_i(ii[2][7:0]),
    .odata_en(oen[2]), .odata_r(or2), .odata_i(oi2));

  assign ordat[0] = or0;
  assign oidat[0] = oi0;
  assign ordat[1] = {8'h00, or1};
  assign oidat[1] = {8'h00, oi1};
  assign ordat[2] = {8'h00, or2};
  assign oidat[2] = {8'h00, oi2};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rev(input int x, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  task automatic check(input string name, input int d, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s dut%0d @cycle %0d: got %0h, expected %0h", name, d, cyc, act, expv);
    end
  endtask

  // Model: a completed frame emits in[k] at natural slot rev(k), starting three
  // cycles after its last sample or right after the previous burst, whichever is later.
  task automatic send(input int d, input logic [15:0] r, input logic [15:0] i);
    int     n;
    longint e0;
    longint start;
    exp_t   e;
    logic [15:0] mr, mi;
    n  = 1 << logn[d];
    mr = (d == 0) ? r : (r & 16'h00FF);
    mi = (d == 0) ? i : (i & 16'h00FF);
    @(negedge clock);
    en[d] = 1'b1;
    ir[d] = mr;
    ii[d] = mi;
    fr[d][cnt[d]] = mr;
    fi[d][cnt[d]] = mi;
    cnt[d]++;
    if (cnt[d] == n) begin
      e0    = cyc + 1;
      start = (e0 + 3 > next_free[d]) ? e0 + 3 : next_free[d];
      for (int m = 0; m < n; m++) begin
        e.r = fr[d][rev(m, logn[d])];
        e.i = fi[d][rev(m, logn[d])];
        e.c = start + m;
        q[d].push_back(e);
      end
      next_free[d] = start + n;
      cnt[d] = 0;
    end
  endtask

  task automatic gap(input int d);
    @(negedge clock);
    en[d] = 1'b0;
  endtask

  // mode 0: gapless, 1: alternating gaps, 2: random gaps, 3: random gaps and random data
  task automatic frame(input int d, input int base, input int mode);
    int n;
    int g;
    n = 1 << logn[d];
    for (int k = 0; k < n; k++) begin
      g = 0;
      if (k > 0 && mode == 1) g = 1;
      if (k > 0 && mode >= 2 && $urandom_range(0, 2) == 0) g = int'($urandom_range(1, 4));
      repeat (g) gap(d);
      if (mode == 3) send(d, 16'($urandom), 16'($urandom));
      else           send(d, 16'(base + k), 16'(-(base + k)));
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clock);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0;
      q[d].delete();
      cnt[d] = 0;
      next_free[d] = 0;
    end
    #1;
    for (int d = 0; d < 3; d++) check("odata_en_in_reset", d, longint'(oen[d]), 0);
    repeat (hold) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) > 0 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check("drain_pending", -1, longint'(q[0].size() + q[1].size() + q[2].size()), 0);
    repeat (8) @(negedge clock);
  endtask

  // Monitor: every presented output must match the head of its scoreboard queue on time.
  always begin
    exp_t e;
    @(negedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (oen[d]) begin
        if (q[d].size() == 0) begin
          check("unexpected_output", d, 1, 0);
        end else begin
          e = q[d].pop_front();
          check("odata_r", d, longint'(ordat[d]), longint'(e.r));
          check("odata_i", d, longint'(oidat[d]), longint'(e.i));
          check("out_cycle", d, cyc, e.c);
        end
      end else if (q[d].size() > 0 && q[d][0].c <= cyc) begin
        e = q[d].pop_front();
        check("missing_output", d, 0, 1);
      end
    end
  end

  initial begin
    int t;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; ir[d] = '0; ii[d] = '0; cnt[d] = 0; next_free[d] = 0;
    end
    do_reset(3);

    frame(0, 0, 0); gap(0); drain();

    for (int f = 0; f < 3; f++) frame(0, 64 * f, 0);
    gap(0); drain();

    frame(0, 0, 1); gap(0); drain();
    frame(0, 0, 2); gap(0); drain();

    for (int k = 0; k < 20; k++) send(0, 16'(500 + k), 16'(-(500 + k)));
    gap(0);
    do_reset(2);
    frame(0, 100, 0); gap(0); drain();

    frame(0, 200, 0); gap(0);
    t = 0;
    while (!oen[0] && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("burst_started", 0, longint'(oen[0]), 1);
    repeat (10) @(negedge clock);
    do_reset(2);
    repeat (80) @(negedge clock);
    frame(0, 300, 0); gap(0); drain();

    frame(1, 0, 0); gap(1);
    frame(2, 0, 0); gap(2); drain();
    repeat (3) frame(1, 0, 3);
    gap(1);
    repeat (4) frame(2, 0, 3);
    gap(2); drain();

    repeat (4) frame(0, 0, 3);
    gap(0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
